fir_decimator: RTL

FIR_DECIMATOR -- requirements
Module: fir_decimator

---
 rtl/fir_decimator.sv | 113 +++++++++++
 1 files changed

// File: rtl/fir_decimator.sv
// Decimating sample buffer: keeps one of every (decim+1) valid samples from the FIR
// filter and queues them in a first-word fall-through circular FIFO with sticky overflow.
module fir_decimator #(
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DW-1:0]            din,
  input  logic                     valid_in,
  input  logic [3:0]               decim,
  input  logic                     clr_ovf,
  input  logic                     ready_in,
  output logic [DW-1:0]            dout,
  output logic                     valid_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [3:0]    phase_reg, phase_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, overflow_next;

  logic [DW-1:0] mem [DEPTH];

  logic keep;
  logic full;
  logic not_empty;
  logic pop;
  logic wr_en;
  logic ovf_event;

  assign keep      = valid_in && (phase_reg == 4'd0);
  assign full      = (count_reg == FULL_COUNT);
  assign not_empty = (count_reg != '0);
  assign pop       = not_empty && ready_in;
  // A full FIFO still accepts a kept sample when the head leaves in the same cycle.
  assign wr_en     = keep && (!full || pop);
  assign ovf_event = keep && full && !pop;

  // Using >= rather than == lets a shrinking decim wrap on the next valid sample.
  always_comb begin
    phase_next = phase_reg;
    if (valid_in) begin
      if (phase_reg >= decim) begin
        phase_next = 4'd0;
      end else begin
        phase_next = phase_reg + 4'd1;
      end
    end
  end

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end

    case ({wr_en, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    if (ovf_event) begin
      overflow_next = 1'b1;
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg    <= 4'd0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      phase_reg    <= phase_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage is deliberately left out of reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  assign valid_out = not_empty;
  assign dout      = not_empty ? mem[rd_ptr_reg] : '0;
  assign count     = count_reg;
  assign overflow  = overflow_reg;

endmodule
